result_writeback: RTL and testbench
===================================

// Module: result_writeback
// PURPOSE
//  Writeback result stage for the multicycle core, successor to the single-mux result path.
//  - Registers the ALU output and the memory read data (MDR).
//  - Sign/zero-extends and aligns loads, then selects among four sources.
//  - Hands the chosen result to the register file through a one-entry valid/ready output buffer.
//  - Generalised in XLEN and register-address width; flags misaligned and illegal loads.
// PARAMETERS
//  XLEN  32  datapath width; legal values 32 or 64 (other values: elaboration $error)
//  RA_W  5   register-file address width
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  alu_result   in   XLEN  combinational ALU output
//  alu_out_en   in   1     capture alu_result into alu_out register
//  mem_rdata    in   XLEN  raw memory read word
//  mem_data_en  in   1     capture mem_rdata into MDR
//  load_funct3  in   3     load type: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU
//  load_addr    in   3     low bits of load address (byte offset)
//  pc_plus4     in   XLEN  link value for JAL/JALR
//  result_sel   in   2     0 alu_out reg, 1 extended load, 2 alu_result direct, 3 pc_plus4
//  result       out  XLEN  combinational selected result (fed back to PC/addr muxes)
//  wb_req       in   1     request to write result to register wb_rd_in
//  wb_rd_in     in   RA_W  destination register
//  wb_busy      out  1     wb_valid & ~wb_ready; requester must hold wb_req
//  wb_valid     out  1     output buffer holds a write
//  wb_ready     in   1     register file accepts write this cycle
//  wb_data      out  XLEN  buffered write data
//  wb_rd        out  RA_W  buffered destination
//  wb_we        out  1     buffered write enable: 0 if rd==0 or load error
//  wb_load_err  out  1     buffered flag: misaligned or illegal load
// BEHAVIOUR
//  Reset:
//  - rst_n low clears alu_out, MDR, wb_valid, wb_data, wb_rd, wb_we and wb_load_err to 0 immediately.
//  - Reset mid-handshake drops any buffered write.
//  Input registers:
//  - alu_out <= alu_result on a clk edge with alu_out_en=1; otherwise held.
//  - MDR <= mem_rdata on a clk edge with mem_data_en=1; otherwise held.
//  - Latency: sel=0 and sel=1 reflect inputs one cycle after capture; sel=2 and sel=3 pass through combinationally.
//  Load extension (from MDR, lane = load_addr):
//  - Byte load: lane = load_addr.
//  - Half load: lane = load_addr[..:1]*2; requires load_addr[0]=0.
//  - Word load: requires load_addr[1:0]=0; lane is load_addr[2] when XLEN=64.
//  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend to XLEN.
//  - LD legal only for XLEN=64, with load_addr=0.
//  - LWU is illegal for XLEN=32; funct3=7 is always illegal; LD is illegal for XLEN=32.
//  - Misaligned or illegal: extended value = 0, load_err = 1 (applies only when result_sel=1).
//  - XLEN=32 ignores load_addr[2].
//  Output buffer (one entry):
//  - Accept when wb_req & (~wb_valid | wb_ready). On accept at a clk edge:
//    wb_valid<=1, wb_data<=result, wb_rd<=wb_rd_in, wb_load_err<=err, wb_we<=(wb_rd_in!=0)&~err.
//  - Drain only (wb_valid & wb_ready & ~accept): wb_valid<=0; other fields hold.
//  - Simultaneous drain and accept: old entry retires and new entry loads in the same cycle, with no bubble.
//  - wb_req while wb_busy: nothing captured; wb_data and wb_rd stay stable while wb_valid & ~wb_ready.
//  - wb_ready while ~wb_valid: ignored.
//  State: EMPTY (wb_valid=0) <-> FULL (wb_valid=1), transitions per the rules above.
// TESTING
//  - Reset: assert rst_n=0 mid-FULL with no clk edge -> all outputs 0 asynchronously; after release, wb_valid stays 0 until wb_req.
//  - ALU path: alu_result=0x1234_5678, alu_out_en=1, sel=0 -> result shows 0x12345678 only after the next edge; sel=2 shows it the same cycle.
//  - Loads (XLEN=32), MDR=0x80F0_7F81:
//    LB at addr 0 -> 0xFFFFFF81; LBU at 3 -> 0x00000080; LH at 2 -> 0xFFFF80F0.
//    LH at 1 -> wb_load_err=1, wb_we=0, data 0.
//  - Handshake: wb_req with rd=5 and wb_ready=0 for 3 cycles -> wb_busy=1 and wb_data stable.
//    Then wb_ready=1 with a new wb_req (rd=6) -> rd 6 loaded with no empty cycle.
//  - x0: wb_req with rd=0 and sel=3, pc_plus4=0x104 -> wb_valid=1, wb_data=0x104, wb_we=0.
//  - XLEN=64: LD at addr 0 with MDR=0x8000_0000_0000_0001 -> full value; LWU at addr 4 -> 0x0000_0000_8000_0000; LD at addr 4 -> err=1.

Source files
------------

// File: rtl/result_writeback.sv
// result_writeback: registers ALU/MDR, extends and aligns loads, selects the result and buffers one register-file write.
module result_writeback #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_out_en,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_data_en,
    input  logic [2:0]      load_funct3,
    input  logic [2:0]      load_addr,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      result_sel,
    output logic [XLEN-1:0] result,
    input  logic            wb_req,
    input  logic [RA_W-1:0] wb_rd_in,
    output logic            wb_busy,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RA_W-1:0] wb_rd,
    output logic            wb_we,
    output logic            wb_load_err
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("result_writeback: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [RA_W-1:0] wb_rd_q, wb_rd_d;
    logic [0:0]      state_q, state_d;
    logic            wb_we_q, wb_we_d, wb_err_q, wb_err_d;
    logic [63:0]     lane, ext;
    logic [2:0]      offset;
    logic            load_bad, load_err, accept;

    // Extension is done at 64 bits and truncated so one path serves both widths.
    always_comb begin
        alu_out_d = alu_out_en ? alu_result : alu_out_q;
        mdr_d     = mem_data_en ? mem_rdata : mdr_q;
        offset    = (XLEN == 64) ? load_addr : {1'b0, load_addr[1:0]};
        lane      = 64'(mdr_q) >> {offset, 3'b000};
        ext       = '0;
        load_bad  = 1'b0;
        case (load_funct3)
            3'd0: ext = {{56{lane[7]}}, lane[7:0]};
            3'd1: begin
                ext      = {{48{lane[15]}}, lane[15:0]};
                load_bad = load_addr[0];
            end
            3'd2: begin
                ext      = {{32{lane[31]}}, lane[31:0]};
                load_bad = |load_addr[1:0];
            end
            3'd3: begin
                ext      = lane;
                load_bad = (XLEN == 32) || (load_addr != 3'd0);
            end
            3'd4: ext = {56'd0, lane[7:0]};
            3'd5: begin
                ext      = {48'd0, lane[15:0]};
                load_bad = load_addr[0];
            end
            3'd6: begin
                ext      = {32'd0, lane[31:0]};
                load_bad = (XLEN == 32) || (|load_addr[1:0]);
            end
            default: load_bad = 1'b1;
        endcase
        if (load_bad) ext = '0;
        result   = (result_sel == 2'd0) ? alu_out_q :
                   (result_sel == 2'd1) ? ext[XLEN-1:0] :
                   (result_sel == 2'd2) ? alu_result : pc_plus4;
        load_err = (result_sel == 2'd1) && load_bad;
        // A full buffer may retire and reload in the same cycle.
        accept    = wb_req && (state_q == EMPTY || wb_ready);
        state_d   = accept ? FULL : (wb_ready ? EMPTY : state_q);
        wb_data_d = accept ? result : wb_data_q;
        wb_rd_d   = accept ? wb_rd_in : wb_rd_q;
        wb_err_d  = accept ? load_err : wb_err_q;
        wb_we_d   = accept ? ((wb_rd_in != '0) && !load_err) : wb_we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            mdr_q     <= '0;
            state_q   <= EMPTY;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_err_q  <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            state_q   <= state_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign wb_valid    = (state_q == FULL);
    assign wb_busy     = (state_q == FULL) && !wb_ready;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_we       = wb_we_q;
    assign wb_load_err = wb_err_q;
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed vectors for the writeback stage at XLEN=32 and XLEN=64.
module tb_result_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_out_en = 1'b0, mem_data_en = 1'b0, wb_req = 1'b0, wb_ready = 1'b0;
    logic [2:0]  load_funct3 = 3'd0, load_addr = 3'd0;
    logic [1:0]  result_sel = 2'd0;
    logic [4:0]  wb_rd_in = 5'd0;
    logic [31:0] alu32 = '0, mem32 = '0, pc32 = '0;
    logic [63:0] alu64 = '0, mem64 = '0, pc64 = '0;
    logic [31:0] r32, d32;
    logic [63:0] r64, d64;
    logic [4:0]  rd32, rd64;
    logic        busy32, v32, we32, err32, busy64, v64, we64, err64;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_writeback #(.XLEN(32), .RA_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .alu_result(alu32), .alu_out_en(alu_out_en),
        .mem_rdata(mem32), .mem_data_en(mem_data_en), .load_funct3(load_funct3),
        .load_addr(load_addr), .pc_plus4(pc32), .result_sel(result_sel), .result(r32),
        .wb_req(wb_req), .wb_rd_in(wb_rd_in), .wb_busy(busy32), .wb_valid(v32),
        .wb_ready(wb_ready), .wb_data(d32), .wb_rd(rd32), .wb_we(we32), .wb_load_err(err32)
    );

    result_writeback #(.XLEN(64), .RA_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .alu_result(alu64), .alu_out_en(alu_out_en),
        .mem_rdata(mem64), .mem_data_en(mem_data_en), .load_funct3(load_funct3),
        .load_addr(load_addr), .pc_plus4(pc64), .result_sel(result_sel), .result(r64),
        .wb_req(wb_req), .wb_rd_in(wb_rd_in), .wb_busy(busy64), .wb_valid(v64),
        .wb_ready(wb_ready), .wb_data(d64), .wb_rd(rd64), .wb_we(we64), .wb_load_err(err64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load32(input logic [2:0] f3, input logic [2:0] addr, input logic [31:0] exp, input string tag);
        load_funct3 = f3;
        load_addr   = addr;
        #1;
        check(tag, r32, exp);
    endtask

    task automatic load64(input logic [2:0] f3, input logic [2:0] addr, input logic [63:0] exp, input string tag);
        load_funct3 = f3;
        load_addr   = addr;
        #1;
        check(tag, r64, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_valid", v32, 0);
        check("rst_data", d32, 0);
        check("rst_alu_out", r32, 0);
        tick();
        check("rst_valid_hold", v32, 0);

        alu32 = 32'h1234_5678;
        alu_out_en = 1'b1;
        #1;
        check("alu_sel0_before", r32, 0);
        result_sel = 2'd2;
        #1;
        check("alu_sel2_direct", r32, 32'h1234_5678);
        result_sel = 2'd0;
        tick();
        alu_out_en = 1'b0;
        alu32 = 32'h0;
        #1;
        check("alu_sel0_after", r32, 32'h1234_5678);

        mem32 = 32'h80F0_7F81;
        mem_data_en = 1'b1;
        tick();
        mem_data_en = 1'b0;
        mem32 = 32'h0;
        result_sel = 2'd1;
        load32(3'd0, 3'd0, 32'hFFFF_FF81, "lb_0");
        load32(3'd4, 3'd3, 32'h0000_0080, "lbu_3");
        load32(3'd1, 3'd2, 32'hFFFF_80F0, "lh_2");
        load32(3'd5, 3'd0, 32'h0000_7F81, "lhu_0");
        load32(3'd2, 3'd4, 32'h80F0_7F81, "lw_4_ignores_a2");
        load32(3'd6, 3'd0, 32'h0, "lwu_illegal32");
        load32(3'd7, 3'd0, 32'h0, "f3_7_illegal");
        load32(3'd1, 3'd1, 32'h0, "lh_1_misaligned");
        wb_req = 1'b1;
        wb_rd_in = 5'd3;
        wb_ready = 1'b1;
        tick();
        wb_req = 1'b0;
        check("lh1_valid", v32, 1);
        check("lh1_err", err32, 1);
        check("lh1_we", we32, 0);
        check("lh1_data", d32, 0);
        tick();
        check("drain_valid", v32, 0);

        result_sel = 2'd2;
        alu32 = 32'hAAAA_0005;
        wb_req = 1'b1;
        wb_rd_in = 5'd5;
        wb_ready = 1'b0;
        tick();
        alu32 = 32'hBBBB_0006;
        for (int i = 0; i < 3; i++) begin
            check("hs_busy", busy32, 1);
            check("hs_data_stable", d32, 32'hAAAA_0005);
            check("hs_rd_stable", rd32, 5);
            check("hs_we", we32, 1);
            tick();
        end
        wb_ready = 1'b1;
        wb_rd_in = 5'd6;
        alu32 = 32'hCCCC_0006;
        #1;
        check("hs_busy_clear", busy32, 0);
        tick();
        wb_req = 1'b0;
        check("b2b_valid", v32, 1);
        check("b2b_rd", rd32, 6);
        check("b2b_data", d32, 32'hCCCC_0006);
        tick();
        check("b2b_drain", v32, 0);

        result_sel = 2'd3;
        pc32 = 32'h104;
        wb_req = 1'b1;
        wb_rd_in = 5'd0;
        wb_ready = 1'b0;
        tick();
        wb_req = 1'b0;
        check("x0_valid", v32, 1);
        check("x0_data", d32, 32'h104);
        check("x0_we", we32, 0);
        check("x0_err", err32, 0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        result_sel = 2'd2;
        alu32 = 32'h77;
        alu_out_en = 1'b1;
        wb_req = 1'b1;
        wb_rd_in = 5'd7;
        tick();
        wb_req = 1'b0;
        alu_out_en = 1'b0;
        check("pre_rst_rd", rd32, 7);
        rst_n = 1'b0;
        #1;
        check("arst_valid", v32, 0);
        check("arst_data", d32, 0);
        check("arst_rd", rd32, 0);
        check("arst_we", we32, 0);
        result_sel = 2'd0;
        #1;
        check("arst_alu_out", r32, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", v32, 0);

        mem64 = 64'h8000_0000_0000_0001;
        mem_data_en = 1'b1;
        tick();
        mem_data_en = 1'b0;
        mem64 = 64'h0;
        result_sel = 2'd1;
        load64(3'd3, 3'd0, 64'h8000_0000_0000_0001, "ld_0");
        load64(3'd6, 3'd4, 64'h0000_0000_8000_0000, "lwu_4");
        load64(3'd2, 3'd4, 64'hFFFF_FFFF_8000_0000, "lw_4_64");
        load64(3'd3, 3'd4, 64'h0, "ld_4_misaligned");
        wb_req = 1'b1;
        wb_rd_in = 5'd9;
        wb_ready = 1'b1;
        tick();
        wb_req = 1'b0;
        check("ld4_valid", v64, 1);
        check("ld4_err", err64, 1);
        check("ld4_we", we64, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
